pm_key_scan: RTL and testbench
==============================

// Module: pm_key_scan
// PURPOSE
//  Scalar-key responder for the Montgomery-ladder point-multiplication controller.
//  Holds the KEY_W-bit scalar k. Classifies k on request (zero / one / general).
//  Locates the leading 1 bit, then hands out the remaining bits MSB-first, one per keyscan_en pulse.
//  Sits beside the PM controller; consumes key_load/key_check/find_key_first/keyscan_en and returns key_state/key_first_found/ki/key_cnt.
// PARAMETERS
//  KEY_W  233  scalar width in bits
//  CNT_W  8    key_cnt width; must satisfy 2**CNT_W > KEY_W
// PORTS
//  CLK              in   1      clock, rising edge
//  RST_N            in   1      asynchronous active-low reset
//  key_load         in   1      capture key_in while high (level); last sampled value wins
//  key_in           in   KEY_W  scalar k, bit KEY_W-1 = MSB
//  key_check        in   1      one-cycle pulse: classify stored key
//  find_key_first   in   1      one-cycle pulse: start leading-one search
//  keyscan_en       in   1      one-cycle pulse: emit next key bit on ki
//  key_state        out  2      00 unchecked, 01 k==0, 11 k==1, 10 k>=2
//  key_first_found  out  1      level: leading 1 located
//  ki               out  1      most recently emitted key bit
//  key_cnt          out  CNT_W  number of key bits consumed from MSB (0..KEY_W)
// BEHAVIOUR
//  Reset (async, RST_N low): state=IDLE, shift reg=0, key_state=00, key_first_found=0, ki=0, key_cnt=0.
//  All outputs are registered. Reset mid-operation aborts everything; no bit is emitted afterwards until a new load.
//  FSM states: IDLE, READY, FIND, SCAN, DONE. key_load has priority over all other inputs in every state.
//  key_load=1 (any state):
//   - sreg<=key_in, state<=READY
//   - key_state<=00, key_first_found<=0, key_cnt<=0, ki<=0
//  key_check: honoured in READY only; ignored elsewhere.
//   - key_state is valid on the next edge; it must be stable by 2 cycles after the pulse.
//   - Result is held until the next key_load.
//  READY & find_key_first:
//   - state<=FIND
//   - A key_check in the same cycle is also honoured.
//  FIND, each cycle:
//   - sreg<=sreg<<1, key_cnt<=key_cnt+1
//   - If sreg[KEY_W-1]==1: key_first_found<=1, state<=SCAN.
//   - Else if key_cnt+1==KEY_W (k==0): state<=DONE, key_first_found stays 0.
//   - Search latency is 1 + (number of leading zeros) cycles, max KEY_W.
//  SCAN & keyscan_en:
//   - ki<=sreg[KEY_W-1], sreg<=sreg<<1, key_cnt<=key_cnt+1 (ki/key_cnt updated 1 cycle after the pulse).
//   - When key_cnt becomes KEY_W: state<=DONE.
//   - keyscan_en held high for N cycles emits N bits.
//  DONE: keyscan_en and find_key_first are ignored; ki, key_cnt and key_first_found hold.
//  Pulses that arrive in an invalid state (keyscan_en in READY/FIND/IDLE, find_key_first outside READY) are ignored; no error flag.
//  key_cnt never exceeds KEY_W and never wraps.
// TESTING
//  T1 load k=0, key_check -> key_state=01 within 2 cycles; find_key_first -> DONE after 233 cycles, key_first_found=0, key_cnt=233.
//  T2 load k=1, key_check -> key_state=11; load k=6 -> key_state returns to 00, then key_check -> 10.
//  T3 load k=2^232|1, find_key_first -> key_first_found=1 after 1 cycle, key_cnt=1.
//     Then 232 keyscan_en pulses -> ki=0 x231, then ki=1; key_cnt=233; state DONE; a further keyscan_en leaves ki and key_cnt unchanged.
//  T4 load k=5, find_key_first -> found after 231 cycles, key_cnt=231; keyscan_en x2 -> (ki,key_cnt)=(0,232) then (1,233).
//  T5 key_load asserted during SCAN at key_cnt=100 -> next cycle key_cnt=0, key_first_found=0, key_state=00, state READY.
//  T6 RST_N low mid-FIND (asynchronous, between edges) -> all outputs 0 immediately.
//     After release, keyscan_en/find_key_first are ignored until a key_load.

Source files
------------

// File: rtl/pm_key_scan.sv
// Scalar-key responder for a Montgomery-ladder point multiplier: stores k, classifies it,
// skips to the leading one, then hands out the remaining bits MSB-first on request.
`timescale 1ns/1ps
module pm_key_scan #(
  parameter int KEY_W = 233,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_check,
  input  logic             find_key_first,
  input  logic             keyscan_en,
  output logic [1:0]       key_state,
  output logic             key_first_found,
  output logic             ki,
  output logic [CNT_W-1:0] key_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    FIND  = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

  state_t           state;
  logic [KEY_W-1:0] sreg;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_bit;

  assign cnt_inc  = key_cnt + CNT_W'(1);
  assign last_bit = (cnt_inc == CNT_LAST);

  function automatic logic [1:0] classify(input logic [KEY_W-1:0] k);
    if (k == '0)
      return 2'b01;
    else if ((k[KEY_W-1:1] == '0) && k[0])
      return 2'b11;
    else
      return 2'b10;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      sreg            <= '0;
      key_state       <= 2'b00;
      key_first_found <= 1'b0;
      ki              <= 1'b0;
      key_cnt         <= '0;
    end else if (key_load) begin
      state           <= READY;
      sreg            <= key_in;
      key_state       <= 2'b00;
      key_first_found <= 1'b0;
      ki              <= 1'b0;
      key_cnt         <= '0;
    end else begin
      case (state)
        READY: begin
          if (key_check)
            key_state <= classify(sreg);
          if (find_key_first)
            state <= FIND;
        end
        FIND: begin
          sreg    <= sreg << 1;
          key_cnt <= cnt_inc;
          // A leading one in the very last position leaves nothing to scan.
          if (sreg[KEY_W-1]) begin
            key_first_found <= 1'b1;
            state           <= last_bit ? DONE : SCAN;
          end else if (last_bit) begin
            state <= DONE;
          end
        end
        SCAN: begin
          if (keyscan_en) begin
            ki      <= sreg[KEY_W-1];
            sreg    <= sreg << 1;
            key_cnt <= cnt_inc;
            if (last_bit)
              state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_key_scan.sv
// Randomized and directed bench for pm_key_scan with a queue-based scoreboard and
// a bit-indexing reference model of the scalar.
`timescale 1ns/1ps
module tb_pm_key_scan;
  localparam int KEY_W = 233;
  localparam int CNT_W = 8;
  localparam int M_IDLE = 0, M_LOADED = 1, M_SEARCH = 2, M_SCAN = 3, M_DONE = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             key_load = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic             key_check = 1'b0;
  logic             find_key_first = 1'b0;
  logic             keyscan_en = 1'b0;
  logic [1:0]       key_state;
  logic             key_first_found;
  logic             ki;
  logic [CNT_W-1:0] key_cnt;

  pm_key_scan #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .key_load(key_load), .key_in(key_in),
    .key_check(key_check), .find_key_first(find_key_first), .keyscan_en(keyscan_en),
    .key_state(key_state), .key_first_found(key_first_found), .ki(ki), .key_cnt(key_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int       at;
    logic [1:0] ks;
    logic     f;
    logic     b;
    int       cnt;
    string    nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: the original key plus how many bits have been consumed.
  logic [KEY_W-1:0] m_k = '0;
  int               m_phase = M_IDLE;
  int               m_cnt = 0;
  int               m_left = 0;
  logic [1:0]       m_ks = 2'b00;
  logic             m_f = 1'b0;
  logic             m_b = 1'b0;

  always @(negedge CLK) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      if (mon_e.at != cyc || key_state !== mon_e.ks || key_first_found !== mon_e.f ||
          ki !== mon_e.b || key_cnt !== CNT_W'(mon_e.cnt)) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got state=%b found=%b ki=%b cnt=%0d want state=%b found=%b ki=%b cnt=%0d",
                 mon_e.nm, cyc, key_state, key_first_found, ki, key_cnt,
                 mon_e.ks, mon_e.f, mon_e.b, mon_e.cnt);
      end
    end
  end

  function automatic logic [1:0] ref_class(input logic [KEY_W-1:0] k);
    if (k == 0) return 2'b01;
    if (k == 1) return 2'b11;
    return 2'b10;
  endfunction

  // Cycles spent searching: leading zeros + 1, or the full width for k==0.
  function automatic int search_len(input logic [KEY_W-1:0] k);
    for (int i = KEY_W - 1; i >= 0; i--)
      if (k[i]) return KEY_W - i;
    return KEY_W;
  endfunction

  function automatic logic [KEY_W-1:0] rand_key();
    logic [KEY_W-1:0] k;
    int r;
    for (int i = 0; i < KEY_W; i++) k[i] = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return {{(KEY_W-1){1'b0}}, 1'b1};
    return k >> $urandom_range(0, KEY_W - 1);
  endfunction

  task automatic model_step(input logic ld, input logic chk, input logic fnd,
                            input logic scn, input logic [KEY_W-1:0] kv);
    if (ld) begin
      m_k = kv; m_phase = M_LOADED; m_ks = 2'b00; m_f = 1'b0; m_b = 1'b0; m_cnt = 0;
    end else begin
      case (m_phase)
        M_LOADED: begin
          if (chk) m_ks = ref_class(m_k);
          if (fnd) begin m_phase = M_SEARCH; m_left = search_len(m_k); end
        end
        M_SEARCH: begin
          m_cnt++;
          m_left--;
          if (m_left == 0) begin
            m_f = (m_k != 0);
            m_phase = (m_k != 0 && m_cnt < KEY_W) ? M_SCAN : M_DONE;
          end
        end
        M_SCAN: if (scn) begin
          m_b = m_k[KEY_W - 1 - m_cnt];
          m_cnt++;
          if (m_cnt == KEY_W) m_phase = M_DONE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic ld, input logic chk, input logic fnd, input logic scn,
                       input logic [KEY_W-1:0] kv, input string nm);
    key_load = ld; key_check = chk; find_key_first = fnd; keyscan_en = scn; key_in = kv;
    model_step(ld, chk, fnd, scn, kv);
    exp_q.push_back('{at: cyc + 1, ks: m_ks, f: m_f, b: m_b, cnt: m_cnt, nm: nm});
    @(posedge CLK); #1;
    key_load = 1'b0; key_check = 1'b0; find_key_first = 1'b0; keyscan_en = 1'b0;
  endtask

  task automatic idle(input int n, input string nm);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, rand_key(), nm);
  endtask

  logic [KEY_W-1:0] kk;
  logic             rl, rc, rf, rs;
  int               r;

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, "reset_state");
    drive(1'b0, 1'b1, 1'b1, 1'b1, rand_key(), "idle_ignore");

    // T1: k == 0
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, "t1_load");
    drive(1'b0, 1'b1, 1'b0, 1'b0, rand_key(), "t1_check");
    idle(2, "t1_hold");
    drive(1'b0, 1'b0, 1'b1, 1'b0, rand_key(), "t1_find");
    idle(235, "t1_search");
    drive(1'b0, 1'b0, 1'b1, 1'b1, rand_key(), "t1_done_ignore");

    // T2: k == 1, then k == 6
    drive(1'b1, 1'b0, 1'b0, 1'b0, KEY_W'(1), "t2_load1");
    drive(1'b0, 1'b1, 1'b0, 1'b0, rand_key(), "t2_check1");
    idle(1, "t2_hold1");
    drive(1'b1, 1'b0, 1'b0, 1'b0, KEY_W'(6), "t2_load6");
    drive(1'b0, 1'b1, 1'b0, 1'b0, rand_key(), "t2_check6");
    idle(1, "t2_hold6");

    // T3: k = 2^232 | 1
    kk = '0; kk[KEY_W-1] = 1'b1; kk[0] = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, kk, "t3_load");
    drive(1'b0, 1'b0, 1'b1, 1'b0, rand_key(), "t3_find");
    idle(1, "t3_found");
    repeat (232) drive(1'b0, 1'b0, 1'b0, 1'b1, rand_key(), "t3_scan");
    drive(1'b0, 1'b0, 1'b0, 1'b1, rand_key(), "t3_extra_scan");
    drive(1'b0, 1'b1, 1'b1, 1'b0, rand_key(), "t3_done_ignore");

    // T4: k = 5
    drive(1'b1, 1'b0, 1'b0, 1'b0, KEY_W'(5), "t4_load");
    drive(1'b0, 1'b0, 1'b1, 1'b0, rand_key(), "t4_find");
    idle(231, "t4_search");
    drive(1'b0, 1'b0, 1'b0, 1'b1, rand_key(), "t4_scan0");
    drive(1'b0, 1'b0, 1'b0, 1'b1, rand_key(), "t4_scan1");
    idle(1, "t4_hold");

    // T5: reload mid-scan at key_cnt == 100
    kk = rand_key(); kk[KEY_W-1] = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, kk, "t5_load");
    drive(1'b0, 1'b1, 1'b1, 1'b0, rand_key(), "t5_check_find");
    idle(1, "t5_found");
    repeat (99) drive(1'b0, 1'b0, 1'b0, 1'b1, rand_key(), "t5_scan");
    drive(1'b1, 1'b0, 1'b0, 1'b1, KEY_W'(2), "t5_reload");
    drive(1'b0, 1'b1, 1'b0, 1'b0, rand_key(), "t5_check");
    idle(1, "t5_hold");

    // T6: asynchronous reset in the middle of a search
    drive(1'b1, 1'b0, 1'b0, 1'b0, KEY_W'(5), "t6_load");
    drive(1'b0, 1'b1, 1'b1, 1'b0, rand_key(), "t6_find");
    idle(50, "t6_search");
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    n_chk++;
    if (key_state !== 2'b00 || key_first_found !== 1'b0 || ki !== 1'b0 || key_cnt !== '0) begin
      n_fail++;
      $display("FAIL t6_async_reset got state=%b found=%b ki=%b cnt=%0d want all zero",
               key_state, key_first_found, ki, key_cnt);
    end
    m_phase = M_IDLE; m_ks = 2'b00; m_f = 1'b0; m_b = 1'b0; m_cnt = 0; m_k = '0;
    @(posedge CLK); #3;
    RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, rand_key(), "t6_after_ignore");
    drive(1'b0, 1'b1, 1'b0, 1'b1, rand_key(), "t6_after_ignore2");
    idle(2, "t6_after_idle");

    // Random traffic, all controls free-running against the model
    repeat (2500) begin
      r  = $urandom_range(0, 199);
      rl = (r < 3);
      rc = (r >= 3 && r < 13);
      rf = (r >= 13 && r < 30);
      rs = 1'($urandom_range(0, 1));
      drive(rl, rc, rf, rs, rand_key(), "random");
    end

    repeat (4) @(negedge CLK);
    if (exp_q.size() > 0) begin
      n_chk  += exp_q.size();
      n_fail += exp_q.size();
      $display("FAIL drain %0d expectations never checked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
